// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display: active-high segment
// patterns (bit 6 = a ... bit 0 = g), digit count and the capture FSM states.
package seg7_pkg;
  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;
endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to hex-nibble decoder; unknown patterns give 0 with err.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  // 1001111 is shared by C and E on the driver side; it resolves to E here.
  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reconstructs the 16-bit value shown on a scanned 4-digit display bus.
// valid is a one-cycle pulse with no ready: hex/digit_err update on that edge and hold.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE    = 4,
  parameter int TIMEOUT_W = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            a_to_g,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   hex,
  output logic                  valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  scan_err,
  output state_t                dbg_state
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]        SETTLE_C = CW'(SETTLE);
  localparam logic [TIMEOUT_W-1:0] WD_MAX   = '1;

  logic [6:0]            seg_s1, seg_s2;
  logic [DIGITS-1:0]     an_s1, an_s2;
  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DIGITS-1:0]     cur_an, cur_an_n;
  logic [DIGITS-1:0]     mask, mask_n;
  logic [4*DIGITS-1:0]   slot_hex, slot_hex_n;
  logic [DIGITS-1:0]     slot_err, slot_err_n;
  logic [TIMEOUT_W-1:0]  wd;
  logic                  an_onehot, sample, bad_an, complete, expire;
  logic [1:0]            idx;
  logic [3:0]            dec_nib;
  logic                  dec_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      an_s1  <= '0;
      an_s2  <= '0;
    end else begin
      seg_s1 <= a_to_g;
      seg_s2 <= seg_s1;
      an_s1  <= an;
      an_s2  <= an_s1;
    end
  end

  seg7_decode u_decode (
    .seg    (seg_s2),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  assign an_onehot = $onehot(an_s2);
  assign idx       = {an_s2[3] | an_s2[2], an_s2[3] | an_s2[1]};
  assign dbg_state = state;

  // cnt counts consecutive cycles the current one-hot anode has been seen,
  // including the cycle it first appeared.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cur_an_n = cur_an;
    sample   = 1'b0;
    bad_an   = 1'b0;
    if (!an_onehot) begin
      bad_an  = (state != ST_IDLE);
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      if (state == ST_IDLE || an_s2 != cur_an) begin
        cur_an_n = an_s2;
        cnt_n    = CW'(1);
        state_n  = ST_SETTLE;
      end else if (state == ST_SETTLE) begin
        cnt_n = cnt + 1'b1;
      end
      if (state_n == ST_SETTLE && cnt_n == SETTLE_C) begin
        sample  = 1'b1;
        state_n = ST_HELD;
      end
    end
  end

  always_comb begin
    slot_hex_n = slot_hex;
    slot_err_n = slot_err;
    mask_n     = mask;
    if (sample) begin
      slot_hex_n[{idx, 2'b00} +: 4] = dec_nib;
      slot_err_n[idx]               = dec_err;
      mask_n                        = mask | an_s2;
    end
  end

  assign complete = sample && (mask_n == '1);
  assign expire   = (mask != '0) && (wd == WD_MAX);

  // A watchdog expiry that coincides with frame completion is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      cur_an <= '0;
    end else if (expire && !complete) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      cur_an <= cur_an_n;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      cur_an <= cur_an_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_hex  <= '0;
      slot_err  <= '0;
      mask      <= '0;
      wd        <= '0;
      hex       <= '0;
      digit_err <= '0;
      valid     <= 1'b0;
      scan_err  <= 1'b0;
    end else begin
      valid    <= 1'b0;
      scan_err <= 1'b0;
      slot_hex <= slot_hex_n;
      slot_err <= slot_err_n;
      if (complete) begin
        hex       <= slot_hex_n;
        digit_err <= slot_err_n;
        valid     <= 1'b1;
        mask      <= '0;
        wd        <= '0;
      end else if (bad_an || expire) begin
        scan_err <= 1'b1;
        mask     <= '0;
        wd       <= '0;
      end else begin
        mask <= mask_n;
        wd   <= (mask != '0) ? wd + 1'b1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: a run-length model of the scanned bus
// checked every cycle, plus a queue of hand-computed frames and literal checks.
module tb_seg7_scan_capture;
  localparam int SETTLE = 4;
  localparam int TW     = 6;
  localparam int WD_MAX = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  a_to_g;
  logic [3:0]  an;
  logic [15:0] hex;
  logic        valid;
  logic [3:0]  digit_err;
  logic        scan_err;
  logic [1:0]  dbg_state;

  seg7_scan_capture #(.SETTLE(SETTLE), .TIMEOUT_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_to_g    (a_to_g),
    .an        (an),
    .hex       (hex),
    .valid     (valid),
    .digit_err (digit_err),
    .scan_err  (scan_err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int serr_cnt = 0;
  int serr_cyc_q[$];
  logic [19:0] exp_q[$];

  // ---------------- behavioural model ----------------
  logic [3:0]  p1_an = '0, p2_an = '0, last_an = '0;
  logic [6:0]  p1_seg = '0, p2_seg = '0;
  int          run = 0, age = 0;
  logic [3:0]  m_mask = '0;
  logic [3:0]  slot_n [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0]  slot_e = '0;
  logic [15:0] exp_hex = '0;
  logic [3:0]  exp_derr = '0;
  logic        exp_valid = 1'b0, exp_serr = 1'b0;

  task automatic decode(input logic [6:0] s, output logic [3:0] n, output logic e);
    n = 4'h0;
    e = 1'b1;
    for (int k = 0; k < 16; k++)
      if (pat[k] == s) begin
        n = k[3:0];
        e = 1'b0;
      end
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] s);
    logic oh, smp, expire, old_nz;
    logic [3:0] n;
    logic e;
    exp_valid = 1'b0;
    exp_serr  = 1'b0;
    oh     = (a == 4'd1) || (a == 4'd2) || (a == 4'd4) || (a == 4'd8);
    old_nz = (m_mask != 0);
    expire = old_nz && (age == WD_MAX);
    smp    = 1'b0;
    if (!oh) begin
      if (run > 0) exp_serr = 1'b1;
      run = 0;
    end else begin
      if (run > 0 && a == last_an) run++;
      else run = 1;
      last_an = a;
      smp = (run == SETTLE);
    end
    if (smp) begin
      decode(s, n, e);
      for (int d = 0; d < 4; d++)
        if (a[d]) begin
          slot_n[d] = n;
          slot_e[d] = e;
          m_mask[d] = 1'b1;
        end
    end
    if (smp && m_mask == 4'hF) begin
      exp_hex   = {slot_n[3], slot_n[2], slot_n[1], slot_n[0]};
      exp_derr  = slot_e;
      exp_valid = 1'b1;
      m_mask    = '0;
      age       = 0;
    end else if (exp_serr || expire) begin
      exp_serr = 1'b1;
      m_mask   = '0;
      age      = 0;
      if (expire) run = 0;
    end else if (old_nz) begin
      age++;
    end else begin
      age = 0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_an = '0; p2_an = '0; p1_seg = '0; p2_seg = '0;
      run = 0; age = 0; m_mask = '0; last_an = '0;
      exp_hex = '0; exp_derr = '0; exp_valid = 1'b0; exp_serr = 1'b0;
    end else begin
      model_step(p2_an, p2_seg);
      p2_an = p1_an; p2_seg = p1_seg;
      p1_an = an;    p1_seg = a_to_g;
    end
  end

  always @(posedge clk) cyc++;

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      vectors++;
      if ({hex, valid, digit_err, scan_err} !== {exp_hex, exp_valid, exp_derr, exp_serr}) begin
        miscompares++;
        $display("FAIL cycle %0d: hex=%h valid=%b derr=%b serr=%b, model hex=%h valid=%b derr=%b serr=%b",
                 cyc, hex, valid, digit_err, scan_err, exp_hex, exp_valid, exp_derr, exp_serr);
      end
      if (valid) begin
        valid_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame: unexpected valid with derr=%b hex=%h", digit_err, hex);
        end else begin
          logic [19:0] w;
          w = exp_q.pop_front();
          if ({digit_err, hex} !== w) begin
            miscompares++;
            $display("FAIL frame: got derr=%b hex=%h, want derr=%b hex=%h", digit_err, hex, w[19:16], w[15:0]);
          end
        end
      end
      if (scan_err) begin
        serr_cnt++;
        serr_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic show_digit(input int d, input logic [6:0] s, input int dwell);
    an     = 4'(1 << d);
    a_to_g = s;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic show_frame(input logic [15:0] v, input int dwell);
    logic [3:0] nib;
    for (int d = 0; d < 4; d++) begin
      nib = v[4*d +: 4];
      show_digit(d, pat[nib], dwell);
    end
  endtask

  task automatic blank(input int n);
    an     = 4'b0000;
    a_to_g = 7'b0000000;
    repeat (n) @(negedge clk);
  endtask

  int v0, s0, c0;

  initial begin
    reset  = 1'b1;
    an     = 4'b0000;
    a_to_g = 7'b0000000;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hex", 32'(hex), 32'h0);
    check("reset_flags", {28'h0, valid, scan_err, 2'b00}, 32'h0);
    check("reset_derr", 32'(digit_err), 32'h0);

    // Ideal scan repeated three frames
    v0 = valid_cnt;
    repeat (3) begin
      exp_q.push_back({4'b0000, 16'h1A2F});
      show_frame(16'h1A2F, 20);
    end
    check("t1_hex", 32'(hex), 32'h1A2F);
    check("t1_valid_count", 32'(valid_cnt - v0), 32'd3);

    // E (1001111) on digit 2, C (1001110) on digit 1
    exp_q.push_back({4'b0000, 16'h0EC0});
    show_digit(0, 7'b1111110, 20);
    show_digit(1, 7'b1001110, 20);
    show_digit(2, 7'b1001111, 20);
    show_digit(3, 7'b1111110, 20);
    check("t2_hex", 32'(hex), 32'h0EC0);

    // Undecodable pattern on digit 3
    exp_q.push_back({4'b1000, 16'h0935});
    show_digit(0, pat[5], 20);
    show_digit(1, pat[3], 20);
    show_digit(2, pat[9], 20);
    show_digit(3, 7'b0000001, 20);
    check("t3_hex", 32'(hex), 32'h0935);
    check("t3_derr", 32'(digit_err), 32'h8);

    // Anode glitch mid-frame, then a clean frame
    s0 = serr_cnt; v0 = valid_cnt;
    show_digit(0, pat[4], 20);
    show_digit(1, pat[5], 20);
    an = 4'b0011;
    repeat (2) @(negedge clk);
    exp_q.push_back({4'b0000, 16'h3C5D});
    show_frame(16'h3C5D, 20);
    check("t4_serr_count", 32'(serr_cnt - s0), 32'd1);
    check("t4_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t4_hex", 32'(hex), 32'h3C5D);

    // Dwell too short to sample
    s0 = serr_cnt; v0 = valid_cnt;
    show_frame(16'h8888, 2);
    check("t5_valid_count", 32'(valid_cnt - v0), 32'd0);

    // Stalled frame: watchdog fires at count 63, then bus blanks
    s0 = serr_cnt; v0 = valid_cnt; c0 = cyc;
    show_digit(0, pat[1], 20);
    show_digit(1, pat[2], 70);
    blank(5);
    check("t6_serr_count", 32'(serr_cnt - s0), 32'd2);
    check("t6_valid_count", 32'(valid_cnt - v0), 32'd0);
    if (serr_cyc_q.size() > s0)
      check("t6_wd_latency", 32'(serr_cyc_q[s0] - c0), 32'd70);
    check("t6_hex_held", 32'(hex), 32'h3C5D);

    // Reset after three digits captured, then a full frame
    show_digit(0, pat[7], 20);
    show_digit(1, pat[7], 20);
    show_digit(2, pat[7], 20);
    #2 reset = 1'b1;
    @(negedge clk);
    check("t7_hex_in_reset", 32'(hex), 32'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    v0 = valid_cnt;
    exp_q.push_back({4'b0000, 16'h7777});
    show_frame(16'h7777, 20);
    check("t7_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t7_hex", 32'(hex), 32'h7777);

    // Completion on the same cycle the watchdog saturates
    s0 = serr_cnt; v0 = valid_cnt;
    exp_q.push_back({4'b0000, 16'hBEEF});
    show_digit(0, pat[15], 21);
    show_digit(1, pat[14], 21);
    show_digit(2, pat[14], 22);
    show_digit(3, pat[11], 20);
    check("t8_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t8_serr_count", 32'(serr_cnt - s0), 32'd0);
    check("t8_hex", 32'(hex), 32'hBEEF);

    check("frames_outstanding", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side companion to the team's multiplexed 7-segment driver. Monitors one 4-digit scanned display bus (active-high segments `a_to_g`, active-high one-hot anode `an`). Reconstructs the 16-bit hex value being shown and reports each complete scan frame with a one-cycle `valid` pulse. Used for on-board loopback self-test and as a bench monitor, one instance per 4-digit half of the display.

## Interface
Parameters:
- `SETTLE`, 4: consecutive cycles a one-hot anode must hold unchanged before its segments are sampled (≥1).
- `TIMEOUT_W`, 22: width of the frame watchdog counter; a frame must complete within 2^TIMEOUT_W − 1 cycles.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `a_to_g`, in, 7: segment lines, bit 6 = a … bit 0 = g; may be asynchronous to `clk`.
- `an`, in, 4: anode lines, `an[i]` = 1 selects digit i (i=0 is least-significant nibble); may be asynchronous.
- `hex`, out, 16: last complete frame, digit i in `hex[4i+3:4i]`.
- `valid`, out, 1: one-cycle pulse when `hex` updates.
- `digit_err`, out, 4: bit i set if digit i of the latched frame had an undecodable pattern; updates with `hex`.
- `scan_err`, out, 1: one-cycle pulse on bad anode or watchdog expiry.

## Operation
- Both input buses pass through a 2-flop synchronizer before any use.
- Decode table (pattern → nibble): 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111.
- The driver emits 1001111 for both C and E; this pattern decodes as E.
- Any other pattern decodes to nibble 0 with the error flag set.
- FSM states:
  - IDLE: waiting for a one-hot anode. On one-hot → SETTLE with the counter loaded to 1.
  - SETTLE: anode unchanged → counter increments. When the counter reaches `SETTLE`, sample the decoded nibble and error flag into digit slot i, set `mask[i]`, go to HELD. Anode changes to another one-hot → restart SETTLE. Anode non-one-hot → scan_err, IDLE.
  - HELD: anode unchanged → stay. New one-hot value → SETTLE. Non-one-hot → scan_err, IDLE.
- Non-one-hot means all-zero or more than one bit set.
- A digit sampled twice within a frame overwrites its slot; the latest value wins.
- Frame complete: when `mask` becomes 4'b1111, copy the slots to `hex` and `digit_err`, pulse `valid`, clear `mask`.
- A scan_err in any state also clears `mask`; partial frames are discarded.
- Watchdog:
  - Counts every cycle while `mask` ≠ 0; cleared when `mask` clears.
  - On saturation it pulses scan_err, clears `mask`, and forces IDLE.

## Timing
- Reset values: `hex` = 0, `valid` = 0, `digit_err` = 0, `scan_err` = 0, FSM = IDLE, `mask` = 0, all counters = 0.
- Input-to-sample latency: 2 sync cycles + `SETTLE` cycles of stable anode.
- `valid` asserts on the cycle after the fourth slot is written; `hex` and `digit_err` change on that same edge and hold until the next frame.
- Bad anode detection: scan_err asserts on the cycle after the synchronized anode goes non-one-hot.
- Frame completion and bad anode on the same cycle: completion wins. `valid` pulses, and scan_err pulses in the following cycle.
- Watchdog expiry on the same cycle as frame completion: completion wins, and no scan_err is raised.
- Reset asserted mid-frame: all state clears immediately, with no `valid` pulse.

## Structure
- `seg7_pkg`: the 16 segment-pattern constants, the FSM state enum, and a `DIGITS` = 4 constant. The existing driver is migrated to these shared constants.
- One sub-module, `seg7_decode`: combinational, `seg` [6:0] → `nibble` [3:0] plus `err`.
- The top level holds the synchronizer, FSM, slots, `mask` and watchdog.

## Test plan
- Ideal scan, `SETTLE` = 4, 20 cycles per digit, display 16'h1A2F → `valid` pulses with `hex` = 16'h1A2F and `digit_err` = 0; repeats every frame.
- Segments 1001111 on digit 2, 1001110 on digit 1, others 0 → `hex` = 16'h0EC0.
- Digit 3 pattern 0000001 → `digit_err` = 4'b1000, `hex[15:12]` = 0.
- Anode glitch 4'b0011 for 2 cycles mid-frame → `scan_err` pulse, no `valid` for that frame, next full frame reported correctly.
- Anode dwell of 2 cycles with `SETTLE` = 4 → no sample, no `valid`; with `TIMEOUT_W` = 6 and a stalled frame → `scan_err` at count 63.
- Reset asserted after 3 digits captured, then a full frame of 16'h7777 → exactly one `valid` pulse, with `hex` = 16'h7777.
